psum_reduce_acc: RTL
====================

Name: psum_reduce_acc

Overview:
- Downstream neighbour of the multiplier-switch array. Consumes the full product bus each valid cycle.
- Reduces all NUM_PES signed products to one sum through a registered binary adder tree.
- Temporally accumulates that sum over a programmable number of beats, emitting one output-stationary partial sum per group.
- Output feeds the writeback/collection stage.

Parameters:
- IN_DATA_TYPE, 16, width of each signed product lane on i_data_bus.
- OUT_DATA_TYPE, 32, width of the signed accumulated result. Must be >= IN_DATA_TYPE + log2(NUM_PES).
- NUM_PES, 32, number of product lanes. Power of two, >= 2.
- ACC_CNT_W, 8, width of the group-length field.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- i_valid  input  1  product bus valid this cycle
- i_data_bus  input  NUM_PES*IN_DATA_TYPE  products; lane k at [k*IN_DATA_TYPE +: IN_DATA_TYPE]
- i_acc_len  input  ACC_CNT_W  beats per accumulation group; sampled on the first beat of each group; 0 treated as 1
- i_flush  input  1  synchronous abort: discards partial sum and all in-flight beats
- o_valid  output  1  one-cycle pulse, group result on o_data
- o_data  output  OUT_DATA_TYPE  accumulated group sum (signed)
- o_busy  output  1  high while a group is open or beats are in the tree

Behaviour:
- Reset (async, rst=1): all tree stage registers and valid bits 0, accumulator 0, beat counter 0, length register 0, state IDLE, o_valid=0, o_data=0, o_busy=0.
- Arithmetic:
  - Lanes are sign-extended to OUT_DATA_TYPE before the first adder level.
  - All additions are two's complement and wrap modulo 2^OUT_DATA_TYPE; no saturation.
- Adder tree:
  - L = log2(NUM_PES) registered levels, each with a valid bit shifted alongside data.
  - A beat presented at cycle t reaches the accumulator input at t+L.
  - The tree holds no stall; it accepts a beat every cycle.
- Accumulator FSM, 2 states, advanced only by tree-output valid (tv):
  - IDLE, tv=1: latch len = max(i_acc_len, 1) as sampled that cycle, acc <= tree_sum, cnt <= 1.
    - If len==1, emit immediately (o_valid next edge) and stay IDLE.
    - Otherwise go to ACCUM.
  - ACCUM, tv=1: acc <= acc + tree_sum, cnt <= cnt + 1.
    - When cnt+1 == len: o_data <= acc + tree_sum, o_valid=1 next cycle, cnt <= 0, go to IDLE.
  - tv=0 in any state: hold everything; gaps between beats are allowed.
  - Back-to-back groups: a beat arriving the cycle after the closing beat starts a new group with no bubble.
- Latency: a group's last input beat at cycle t produces o_valid at t+L+1.
- o_valid:
  - High for exactly one cycle per group.
  - o_data holds its value until the next group completes.
- i_acc_len is sampled only on a group's first tree-output beat. Changes mid-group are ignored.
- i_flush (synchronous, highest priority):
  - Next edge clears all tree valid bits, acc, cnt, and state to IDLE. o_data is unchanged; o_valid=0.
  - An input beat coinciding with i_flush is dropped.
  - A group that would complete in the flush cycle is dropped; no o_valid.
- o_busy = (state==ACCUM) | OR of tree valid bits. Registered-state derived; glitch-free.
- Reset asserted mid-group: everything returns to reset values immediately; no o_valid for the partial group.

Test Plan:
- NUM_PES=8, all lanes 3, i_acc_len=1, single beat at cycle 0 -> o_valid pulse at cycle 4, o_data=24, o_busy low from cycle 4.
- NUM_PES=8, i_acc_len=4, four consecutive beats lanes = beat index+1 (1,2,3,4) -> one o_valid at cycle 3+3+1=7, o_data=8*(1+2+3+4)=80; no other pulses.
- Signed/wrap: lanes all -1 (0xFFFF), len=2 -> o_data=-16. Then OUT_DATA_TYPE=20 with lanes 0x7FFF, len=32 (NUM_PES=32) -> result wraps modulo 2^20.
- Back-to-back: len=2, 6 consecutive beats of all-ones lanes -> three o_valid pulses spaced 2 cycles apart, each o_data=2*NUM_PES. Repeat with a 3-cycle i_valid gap mid-group -> same sums, pulses delayed by the gap.
- i_acc_len=0 and a len change from 3 to 5 mid-group -> len 0 behaves as 1; the mid-group change is ignored, and the group closes after 3 beats.
- Flush/reset: i_flush on the cycle of the closing beat -> no o_valid, o_data retains its previous value, and the next group sums from 0. Async rst mid-group (between clock edges) -> outputs immediately 0, and the next group is correct.

Source files
------------

// File: rtl/psum_reduce_acc.sv
// Reduces NUM_PES signed products through a registered binary adder tree, then
// accumulates the tree output over a programmable number of beats per group.

module psum_add_node #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum <= '0;
        else     sum <= a + b;
    end
endmodule

module psum_reduce_acc #(
    parameter int IN_DATA_TYPE  = 16,
    parameter int OUT_DATA_TYPE = 32,
    parameter int NUM_PES       = 32,
    parameter int ACC_CNT_W     = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_valid,
    input  logic [NUM_PES*IN_DATA_TYPE-1:0] i_data_bus,
    input  logic [ACC_CNT_W-1:0]            i_acc_len,
    input  logic                            i_flush,
    output logic                            o_valid,
    output logic [OUT_DATA_TYPE-1:0]        o_data,
    output logic                            o_busy
);
    localparam int L = $clog2(NUM_PES);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    logic [NUM_PES-1:0][OUT_DATA_TYPE-1:0] lane_ext;
    // Heap-ordered tree: node[1] is the root, node[n] sums children 2n and 2n+1;
    // child indices >= NUM_PES refer to the sign-extended lanes.
    logic [NUM_PES-1:1][OUT_DATA_TYPE-1:0] node;
    logic [L:0]                            vld_pipe;

    genvar k, n;
    generate
        for (k = 0; k < NUM_PES; k++) begin : g_lane
            assign lane_ext[k] = {{(OUT_DATA_TYPE-IN_DATA_TYPE){i_data_bus[k*IN_DATA_TYPE+IN_DATA_TYPE-1]}},
                                  i_data_bus[k*IN_DATA_TYPE +: IN_DATA_TYPE]};
        end
        for (n = 1; n < NUM_PES; n++) begin : g_node
            if (2*n >= NUM_PES) begin : g_leaf
                psum_add_node #(.W(OUT_DATA_TYPE)) u_add (
                    .clk (clk),
                    .rst (rst),
                    .a   (lane_ext[2*n-NUM_PES]),
                    .b   (lane_ext[2*n+1-NUM_PES]),
                    .sum (node[n])
                );
            end else begin : g_inner
                psum_add_node #(.W(OUT_DATA_TYPE)) u_add (
                    .clk (clk),
                    .rst (rst),
                    .a   (node[2*n]),
                    .b   (node[2*n+1]),
                    .sum (node[n])
                );
            end
        end
    endgenerate

    // Tree data needs no flush; clearing the valid bits is enough to drop beats.
    assign vld_pipe[0] = i_valid;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          vld_pipe[L:1] <= '0;
        else if (i_flush) vld_pipe[L:1] <= '0;
        else              vld_pipe[L:1] <= vld_pipe[L-1:0];
    end

    logic [0:0]               state;
    logic [OUT_DATA_TYPE-1:0] acc, acc_sum, tree_sum;
    logic [ACC_CNT_W-1:0]     cnt, cnt_inc, len_q, len_eff;
    logic                     tv;

    assign tv       = vld_pipe[L];
    assign tree_sum = node[1];
    assign acc_sum  = acc + tree_sum;
    assign cnt_inc  = cnt + ACC_CNT_W'(1);
    assign len_eff  = (i_acc_len == '0) ? ACC_CNT_W'(1) : i_acc_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            acc     <= '0;
            cnt     <= '0;
            len_q   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (i_flush) begin
            state   <= ST_IDLE;
            acc     <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (tv) begin
                if (state == ST_IDLE) begin
                    len_q <= len_eff;
                    acc   <= tree_sum;
                    cnt   <= ACC_CNT_W'(1);
                    if (len_eff == ACC_CNT_W'(1)) begin
                        o_data  <= tree_sum;
                        o_valid <= 1'b1;
                    end else begin
                        state <= ST_ACCUM;
                    end
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt_inc;
                    if (cnt_inc == len_q) begin
                        o_data  <= acc_sum;
                        o_valid <= 1'b1;
                        cnt     <= '0;
                        state   <= ST_IDLE;
                    end
                end
            end
        end
    end

    assign o_busy = (state == ST_ACCUM) | (|vld_pipe[L:1]);
endmodule
